// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter for NPORTS read/write channels sharing one
// asynchronous SRAM. A registered four-state FSM (IDLE, SETUP, ACCESS, DONE)
// sequences the active-low CE/OE/WE strobes. The strobe is held low for
// WAIT_CYCLES cycles. Each transaction ends with a one-cycle ack pulse to the
// granted channel.
module sram_arbiter #(
   parameter int NPORTS      = 2,
   parameter int DATA_W      = 16,
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NPORTS-1:0]        req,
   input  logic [NPORTS-1:0]        we,
   input  logic [NPORTS*ADDR_W-1:0] addr,
   input  logic [NPORTS*DATA_W-1:0] wdata,
   output logic [NPORTS-1:0]        ack,
   output logic [DATA_W-1:0]        rdata,
   inout  wire  [DATA_W-1:0]        dataBus,
   output logic [ADDR_W-1:0]        addrBus,
   output logic                     memRead,
   output logic                     memWrite,
   output logic                     memEnable
);

   localparam int IDX_W = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int CNT_W = $clog2(WAIT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETUP,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   grant_q, grant_d;
   logic [IDX_W-1:0]   last_grant_q, last_grant_d;
   logic               we_q, we_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [DATA_W-1:0]  wdata_q, wdata_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  rdata_q, rdata_d;

   logic               sel_valid;
   logic [IDX_W-1:0]   sel_idx;
   logic               drive_bus;

   // Unpacked views of the packed channel buses, indexed by grant number.
   logic [ADDR_W-1:0]  addr_arr  [NPORTS];
   logic [DATA_W-1:0]  wdata_arr [NPORTS];

   for (genvar i = 0; i < NPORTS; i++) begin : g_unpack
      assign addr_arr[i]  = addr[i*ADDR_W +: ADDR_W];
      assign wdata_arr[i] = wdata[i*DATA_W +: DATA_W];
   end

   // Round-robin pick: the first requester at or after last_grant+1, wrapping.
   always_comb begin : arb
      logic [IDX_W-1:0] cand;
      // NOTE: every combinational output gets a default before any branch,
      // so no path through the block can leave it unassigned and infer a latch.
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NPORTS; k++) begin
         cand = IDX_W'((int'(last_grant_q) + 1 + k) % NPORTS);
         if (!sel_valid && req[cand]) begin
            sel_valid = 1'b1;
            sel_idx   = cand;
         end
      end
   end

   // Next-state, datapath updates and strobe/ack decode from the registered state.
   always_comb begin : fsm_comb
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      memEnable    = 1'b1;
      memRead      = 1'b1;
      memWrite     = 1'b1;
      drive_bus    = 1'b0;
      ack          = '0;

      case (state_q)
         S_IDLE: begin
            // The request is latched here, so later input changes cannot disturb the cycle.
            if (sel_valid) begin
               grant_d = sel_idx;
               we_d    = we[sel_idx];
               addr_d  = addr_arr[sel_idx];
               wdata_d = wdata_arr[sel_idx];
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            memEnable = 1'b0;
            drive_bus = we_q;
            cnt_d     = CNT_W'(WAIT_CYCLES);
            state_d   = S_ACCESS;
         end
         S_ACCESS: begin
            memEnable = 1'b0;
            drive_bus = we_q;
            memRead   = we_q;
            memWrite  = !we_q;
            cnt_d     = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Sample read data at the edge that closes the last strobe cycle.
               if (!we_q) begin
                  rdata_d = dataBus;
               end
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            // Strobes are released; CE and write data are held one more cycle.
            memEnable     = 1'b0;
            drive_bus     = we_q;
            ack[grant_q]  = 1'b1;
            last_grant_d  = grant_q;
            state_d       = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: flops use non-blocking assignments so every _q takes its new
      // value together at the edge, independent of statement order.
      if (!rst) begin
         state_q      <= S_IDLE;
         grant_q      <= '0;
         last_grant_q <= IDX_W'(NPORTS - 1);
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         cnt_q        <= '0;
         rdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         cnt_q        <= cnt_d;
         rdata_q      <= rdata_d;
      end
   end

   assign addrBus = addr_q;
   assign rdata   = rdata_q;
   assign dataBus = drive_bus ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: drives sram_arbiter with directed scenarios and randomized
// requesters. An asynchronous SRAM model sits on the shared bus. A
// transaction-level timing model of the arbiter is checked every cycle.
module tb_sram_arbiter;

   localparam int NP = 3;
   localparam int DW = 16;
   localparam int AW = 18;
   localparam int WC = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP-1:0]   req;
   logic [NP-1:0]   we;
   logic [NP*AW-1:0] addr;
   logic [NP*DW-1:0] wdata;
   logic [NP-1:0]   ack;
   logic [DW-1:0]   rdata;
   wire  [DW-1:0]   dataBus;
   logic [AW-1:0]   addrBus;
   logic            memRead, memWrite, memEnable;

   always #5 clk = ~clk;

   sram_arbiter #(
      .NPORTS(NP), .DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(WC)
   ) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .ack(ack), .rdata(rdata), .dataBus(dataBus), .addrBus(addrBus),
      .memRead(memRead), .memWrite(memWrite), .memEnable(memEnable)
   );

   // Asynchronous SRAM: drives data while CE and OE are low, stores while CE and WE are low.
   logic [DW-1:0] sram [1024];
   assign dataBus = (!memEnable && !memRead) ? sram[addrBus[9:0]] : {DW{1'bz}};
   always @(posedge clk) begin
      if (!memEnable && !memWrite) sram[addrBus[9:0]] <= dataBus;
   end

   // Probe: when nobody should drive the bus, the bench drives zeros; a DUT
   // that fails to release the bus shows up as a non-zero or unknown value.
   logic probe_en = 1'b0;
   assign dataBus = probe_en ? {DW{1'b0}} : {DW{1'bz}};

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level reference model ----------------
   int            cyc = 0;
   bit            m_known = 1'b0;
   bit            m_tv = 1'b0;
   int            m_start, m_g, m_last, m_next_free, m_c;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_rdv, m_base_rdata;
   logic [DW-1:0] golden [1024];

   // At each edge: retire a completed write, apply reset, or grant a new transaction.
   always @(posedge clk) begin : model
      if (m_tv && m_we && cyc == m_start + 2 + WC) golden[m_addr[9:0]] = m_wdata;
      if (rst === 1'b0) begin
         m_known      = 1'b1;
         m_tv         = 1'b0;
         m_next_free  = cyc + 1;
         m_last       = NP - 1;
         m_base_rdata = '0;
      end else if (m_known && cyc >= m_next_free && req != '0) begin
         if (m_tv && !m_we) m_base_rdata = m_rdv;
         m_g = -1;
         for (int k = 0; k < NP; k++) begin
            m_c = (m_last + 1 + k) % NP;
            if (m_g < 0 && req[m_c]) m_g = m_c;
         end
         m_tv        = 1'b1;
         m_start     = cyc;
         m_we        = we[m_g];
         m_addr      = addr[m_g*AW +: AW];
         m_wdata     = wdata[m_g*DW +: DW];
         m_rdv       = golden[m_addr[9:0]];
         m_last      = m_g;
         m_next_free = cyc + 3 + WC;
      end
      cyc++;
   end

   // Expected outputs for the current cycle, derived from the transaction's phase.
   logic          e_me, e_mr, e_mw, e_drive;
   logic [NP-1:0] e_ack;
   logic [AW-1:0] e_addr;
   logic [DW-1:0] e_rd;
   int            e_p;

   always @(posedge clk) begin : compare
      #1;
      e_me = 1'b1; e_mr = 1'b1; e_mw = 1'b1; e_drive = 1'b0;
      e_ack = '0; e_addr = '0; e_rd = m_base_rdata; e_p = 0;
      if (m_tv) begin
         e_p    = cyc - m_start;
         e_addr = m_addr;
         if (e_p >= 1 && e_p <= 2 + WC) begin
            e_me    = 1'b0;
            e_drive = m_we;
         end
         if (e_p >= 2 && e_p <= 1 + WC) begin
            if (m_we) e_mw = 1'b0;
            else      e_mr = 1'b0;
         end
         if (e_p == 2 + WC) e_ack[m_g] = 1'b1;
         if (!m_we && e_p >= 2 + WC) e_rd = m_rdv;
      end
      probe_en = m_known && !e_drive && e_mr;
      #2;
      if (m_known) begin
         check("memEnable", memEnable, e_me);
         check("memRead",   memRead,   e_mr);
         check("memWrite",  memWrite,  e_mw);
         check("ack",       ack,       e_ack);
         check("addrBus",   addrBus,   e_addr);
         check("rdata",     rdata,     e_rd);
         if (e_drive)   check("dataBus_wdata",    dataBus, m_wdata);
         else if (e_mr) check("dataBus_released", dataBus, {DW{1'b0}});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_fields(input int ch);
      we[ch]              = 1'($urandom_range(0, 1));
      addr[ch*AW +: AW]   = AW'($urandom);
      wdata[ch*DW +: DW]  = DW'($urandom);
   endtask

   // One transaction on one channel; optionally changes its address at the SETUP cycle.
   task automatic xact(input int ch, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [AW-1:0] a_after,
                       output int ack_at, output int strb, output int abad,
                       output logic [DW-1:0] rd);
      req[ch]            = 1'b1;
      we[ch]             = w;
      addr[ch*AW +: AW]  = a;
      wdata[ch*DW +: DW] = d;
      ack_at = -1; strb = 0; abad = 0; rd = '0;
      for (int k = 1; k <= 40 && ack_at < 0; k++) begin
         @(negedge clk);
         if (k == 1) addr[ch*AW +: AW] = a_after;
         if (!memEnable && addrBus !== a) abad++;
         if (w ? !memWrite : !memRead) strb++;
         if (ack[ch]) begin
            ack_at  = k;
            rd      = rdata;
            req[ch] = 1'b0;
         end
      end
   endtask

   task automatic wait_ack(output int ch, output int k);
      ch = -1; k = -1;
      for (int i = 1; i <= 40 && ch < 0; i++) begin
         @(negedge clk);
         for (int j = 0; j < NP; j++) begin
            if (ack[j]) begin
               ch = j;
               k  = i;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int            ack_at, strb, abad, ch, k, found, n_rand_acks, r;
   logic [DW-1:0] rd;
   int            rr_exp [6] = '{0, 1, 2, 0, 1, 2};

   initial begin : main
      rst = 1'b0; req = '0; we = '0; addr = '0; wdata = '0;
      n_rand_acks = 0;
      for (int i = 0; i < 1024; i++) begin
         sram[i]   = DW'(i * 3 + 1);
         golden[i] = DW'(i * 3 + 1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Idle after reset with no requests.
      repeat (3) begin
         @(negedge clk);
         check("idle_memEnable", memEnable, 1'b1);
         check("idle_memRead",   memRead,   1'b1);
         check("idle_memWrite",  memWrite,  1'b1);
         check("idle_ack",       ack,       '0);
         check("idle_rdata",     rdata,     '0);
         check("idle_dataBus",   dataBus,   '0);
      end

      // Write 16'hBEEF to 18'h00010 on ch0, then read it back.
      @(negedge clk);
      xact(0, 1'b1, 18'h00010, 16'hBEEF, 18'h00010, ack_at, strb, abad, rd);
      check("wr_ack_cycle",    ack_at, 4);
      check("wr_strobe_width", strb,   2);
      check("wr_addr_stable",  abad,   0);
      @(negedge clk);
      xact(0, 1'b0, 18'h00010, 16'h0000, 18'h00010, ack_at, strb, abad, rd);
      check("rd_ack_cycle",    ack_at, 4);
      check("rd_strobe_width", strb,   2);
      check("rd_data",         rd,     16'hBEEF);

      // All channels requesting continuously: 0,1,2,0,1,2 spaced 3+WAIT_CYCLES.
      do_reset();
      @(negedge clk);
      req = '1; we = '0;
      for (int i = 0; i < NP; i++) addr[i*AW +: AW] = AW'(i + 8);
      for (int n = 0; n < 6; n++) begin
         wait_ack(ch, k);
         check($sformatf("rr_order%0d", n),   ch, rr_exp[n]);
         check($sformatf("rr_spacing%0d", n), k,  (n == 0) ? 4 : 5);
      end
      req = '0;

      // Priority rotation: after ch1 is served, ch0 wins over a continuous ch1.
      @(negedge clk);
      xact(1, 1'b0, 18'h00100, 16'h0000, 18'h00100, ack_at, strb, abad, rd);
      check("prio_ch1_alone", ack_at, 4);
      @(negedge clk);
      req[0] = 1'b1; we[0] = 1'b0; addr[0*AW +: AW] = 18'h00011;
      req[1] = 1'b1; we[1] = 1'b0; addr[1*AW +: AW] = 18'h00012;
      wait_ack(ch, k);
      check("prio_first", ch, 0);
      req[0] = 1'b0;
      wait_ack(ch, k);
      check("prio_second", ch, 1);
      req[1] = 1'b0;

      // Reset while the write strobe is low aborts; the pending request is redone.
      @(negedge clk);
      req[2] = 1'b1; we[2] = 1'b1; addr[2*AW +: AW] = 18'h00055; wdata[2*DW +: DW] = 16'h1234;
      found = 0;
      for (int i = 0; i < 10 && found == 0; i++) begin
         @(negedge clk);
         if (memWrite === 1'b0) found = 1;
      end
      check("rst_reached_access", found, 1);
      rst = 1'b0;
      @(negedge clk);
      check("rst_abort_memEnable", memEnable, 1'b1);
      check("rst_abort_memRead",   memRead,   1'b1);
      check("rst_abort_memWrite",  memWrite,  1'b1);
      check("rst_abort_ack",       ack,       '0);
      check("rst_abort_dataBus",   dataBus,   '0);
      rst = 1'b1;
      xact(2, 1'b1, 18'h00055, 16'h1234, 18'h00055, ack_at, strb, abad, rd);
      check("rst_retry_ack_cycle", ack_at, 4);
      check("rst_retry_strobe",    strb,   2);
      @(negedge clk);
      xact(2, 1'b0, 18'h00055, 16'h0000, 18'h00055, ack_at, strb, abad, rd);
      check("rst_retry_readback",  rd,     16'h1234);

      // Address changes during SETUP must not reach the bus.
      @(negedge clk);
      xact(0, 1'b1, 18'h00020, 16'hA5A5, 18'h00030, ack_at, strb, abad, rd);
      check("addr_change_ack",    ack_at, 4);
      check("addr_change_stable", abad,   0);
      @(negedge clk);
      xact(0, 1'b0, 18'h00020, 16'h0000, 18'h00020, ack_at, strb, abad, rd);
      check("addr_change_readback", rd, 16'hA5A5);

      // Randomized requesters following the handshake, with input churn and withdrawals.
      @(negedge clk);
      for (int t = 0; t < 1500; t++) begin
         @(negedge clk);
         for (int i = 0; i < NP; i++) begin
            if (ack[i]) begin
               n_rand_acks++;
               if ($urandom_range(0, 1) == 1) begin
                  req[i] = 1'b1;
                  set_fields(i);
               end else begin
                  req[i] = 1'b0;
               end
            end else if (!req[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  req[i] = 1'b1;
                  set_fields(i);
               end
            end else begin
               r = int'($urandom_range(0, 31));
               if (r < 3)       set_fields(i);
               else if (r == 3) req[i] = 1'b0;
            end
         end
      end
      req = '0;
      repeat (10) @(negedge clk);
      check("rand_progress", n_rand_acks > 50, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
